hand_packet_tx: RTL and testbench

Serializes the sorted left/right hand coordinates into a framed byte packet for the drone link. Once per video frame, the tracking pipeline pulses `frame_done` while the hand sorter's left/right outputs are stable. This block snapshots all six coordinates and streams a 15-byte packet over a valid/ready byte interface to the UART/radio transmitter. Frames that arrive while a packet is still in flight are dropped and counted.

---
 rtl/hand_packet_tx.sv | 154 +++++++++++++++
 tb/tb_hand_packet_tx.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/hand_packet_tx.sv
// Snapshots left/right hand coordinates on frame_done and streams them as a
// 15-byte framed packet (sync, seq, 12 coordinate bytes, checksum) over valid/ready.
module hand_packet_tx #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        frame_done,
  input  logic [15:0] left_x,
  input  logic [15:0] left_y,
  input  logic [15:0] left_z,
  input  logic [15:0] right_x,
  input  logic [15:0] right_y,
  input  logic [15:0] right_z,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic [7:0]  seq,
  output logic [7:0]  dropped_count
);

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned IDX_W     = 4;
  localparam int unsigned NUM_BYTES = 12;

  localparam logic [IDX_W-1:0]  LAST_IDX  = 4'd14;
  localparam logic [IDX_W-1:0]  FIRST_CRD = 4'd2;
  localparam logic [IDX_W-1:0]  LAST_CRD  = 4'd13;
  localparam logic [BYTE_W-1:0] DROP_MAX  = 8'hFF;

  typedef logic [NUM_BYTES-1:0][BYTE_W-1:0] snap_t;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t            state, state_d;
  logic [IDX_W-1:0]  idx, idx_d;
  snap_t             snap, snap_d;
  logic [BYTE_W-1:0] seq_r, seq_d;
  logic [BYTE_W-1:0] drop_r, drop_d;
  logic [BYTE_W-1:0] data_r, data_d;

  snap_t frame_snap;
  logic  xfer;
  logic  last_xfer;
  logic  accept;
  logic  drop;

  // Byte 11 of the snapshot is left_x high byte, byte 0 is right_z low byte.
  assign frame_snap = {left_x, left_y, left_z, right_x, right_y, right_z};

  assign xfer      = (state == SEND) && tx_ready;
  assign last_xfer = xfer && (idx == LAST_IDX);
  assign accept    = frame_done && ((state == IDLE) || last_xfer);
  assign drop      = frame_done && (state == SEND) && !last_xfer;

  function automatic logic [BYTE_W-1:0] checksum(input snap_t s, input logic [BYTE_W-1:0] sq);
    logic [BYTE_W-1:0] sum;
    sum = sq;
    for (int i = 0; i < NUM_BYTES; i++) begin
      sum = sum + s[4'(i)];
    end
    return sum;
  endfunction

  function automatic logic [BYTE_W-1:0] payload_byte(input logic [IDX_W-1:0] k,
                                                      input snap_t s,
                                                      input logic [BYTE_W-1:0] sq);
    logic [BYTE_W-1:0] b;
    b = '0;
    if (k == 4'd0) begin
      b = SYNC_BYTE;
    end else if (k == 4'd1) begin
      b = sq;
    end else if (k >= FIRST_CRD && k <= LAST_CRD) begin
      b = s[LAST_CRD - k];
    end else if (k == LAST_IDX) begin
      b = checksum(s, sq);
    end
    return b;
  endfunction

  // State, index, snapshot and all output registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= IDLE;
      idx    <= '0;
      snap   <= '0;
      seq_r  <= '0;
      drop_r <= '0;
      data_r <= '0;
    end else begin
      state  <= state_d;
      idx    <= idx_d;
      snap   <= snap_d;
      seq_r  <= seq_d;
      drop_r <= drop_d;
      data_r <= data_d;
    end
  end

  // Next-state and next-output logic; tx_data is preloaded with the byte at idx_d
  always_comb begin
    state_d = state;
    idx_d   = idx;
    snap_d  = snap;
    seq_d   = seq_r;
    drop_d  = drop_r;
    data_d  = data_r;
    unique case (state)
      IDLE: begin
        if (frame_done) begin
          state_d = SEND;
          idx_d   = '0;
          snap_d  = frame_snap;
          data_d  = SYNC_BYTE;
        end
      end
      SEND: begin
        if (last_xfer) begin
          seq_d = seq_r + 8'd1;
        end
        if (accept) begin
          idx_d  = '0;
          snap_d = frame_snap;
          data_d = SYNC_BYTE;
        end else if (last_xfer) begin
          state_d = IDLE;
          idx_d   = '0;
          data_d  = '0;
        end else if (xfer) begin
          idx_d  = idx + 4'd1;
          data_d = payload_byte(idx + 4'd1, snap, seq_r);
        end
        if (drop && (drop_r != DROP_MAX)) begin
          drop_d = drop_r + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign tx_valid      = (state == SEND);
  assign busy          = (state == SEND);
  assign tx_data       = data_r;
  assign seq           = seq_r;
  assign dropped_count = drop_r;

endmodule

// File: tb/tb_hand_packet_tx.sv
// Directed bench for hand_packet_tx: packet framing, backpressure, drops,
// back-to-back acceptance, seq wrap and reset mid-packet.
module tb_hand_packet_tx;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        frame_done;
  logic [15:0] left_x, left_y, left_z, right_x, right_y, right_z;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic [7:0]  seq;
  logic [7:0]  dropped_count;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_pkt [15];

  always #5 clk = ~clk;

  hand_packet_tx #(.SYNC_BYTE(8'hA5)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .frame_done   (frame_done),
    .left_x       (left_x),
    .left_y       (left_y),
    .left_z       (left_z),
    .right_x      (right_x),
    .right_y      (right_y),
    .right_z      (right_z),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .busy         (busy),
    .seq          (seq),
    .dropped_count(dropped_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_coords(input logic [15:0] lx, ly, lz, rx, ry, rz);
    left_x = lx; left_y = ly; left_z = lz;
    right_x = rx; right_y = ry; right_z = rz;
  endtask

  // Reference packet: sync, seq, six coordinates high byte first, sum of bytes 1..13
  task automatic build_pkt(input logic [7:0] s, input logic [15:0] lx, ly, lz, rx, ry, rz);
    logic [7:0] sum;
    exp_pkt[0]  = 8'hA5;
    exp_pkt[1]  = s;
    exp_pkt[2]  = lx[15:8]; exp_pkt[3]  = lx[7:0];
    exp_pkt[4]  = ly[15:8]; exp_pkt[5]  = ly[7:0];
    exp_pkt[6]  = lz[15:8]; exp_pkt[7]  = lz[7:0];
    exp_pkt[8]  = rx[15:8]; exp_pkt[9]  = rx[7:0];
    exp_pkt[10] = ry[15:8]; exp_pkt[11] = ry[7:0];
    exp_pkt[12] = rz[15:8]; exp_pkt[13] = rz[7:0];
    sum = 8'h00;
    for (int i = 1; i < 14; i++) sum = sum + exp_pkt[i];
    exp_pkt[14] = sum;
  endtask

  task automatic send_frame();
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
  endtask

  // Receive one packet; bp gives ready pattern 1,0,0; fmask pulses frame_done on that byte's transfer
  task automatic rx_packet(input bit bp, input logic [14:0] fmask);
    int b = 0;
    int cyc = 0;
    logic [14:0] fired = '0;
    while (b < 15 && cyc < 200) begin
      tx_ready = bp ? ((cyc % 3) == 0) : 1'b1;
      frame_done = tx_ready && fmask[b] && !fired[b];
      if (frame_done) fired[b] = 1'b1;
      chk("tx_valid", 32'(tx_valid), 32'd1);
      chk($sformatf("tx_data[%0d]", b), 32'(tx_data), 32'(exp_pkt[b]));
      if (b == 0) chk("busy", 32'(busy), 32'd1);
      tick();
      frame_done = 1'b0;
      if (tx_ready) b++;
      cyc++;
    end
    if (b < 15) chk("rx_timeout", 32'(b), 32'd15);
    tx_ready = 1'b1;
  endtask

  initial begin
    reset_n    = 1'b0;
    frame_done = 1'b1;
    tx_ready   = 1'b1;
    set_coords(16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6);
    tick();
    tick();
    frame_done = 1'b0;
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'h00);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_seq", 32'(seq), 32'd0);
    chk("rst_dropped", 32'(dropped_count), 32'd0);
    reset_n = 1'b1;
    tick();
    chk("idle_after_rst", 32'(tx_valid), 32'd0);

    // Basic packet
    exp_pkt = '{8'hA5, 8'h00, 8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03,
                8'h00, 8'h04, 8'h00, 8'h05, 8'h00, 8'h06, 8'h15};
    send_frame();
    rx_packet(1'b0, 15'h0000);
    chk("basic_busy_end", 32'(busy), 32'd0);
    chk("basic_seq", 32'(seq), 32'd1);

    // Backpressure
    exp_pkt = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03,
                8'h00, 8'h04, 8'h00, 8'h05, 8'h00, 8'h06, 8'h16};
    send_frame();
    rx_packet(1'b1, 15'h0000);
    chk("bp_busy_end", 32'(busy), 32'd0);
    chk("bp_seq", 32'(seq), 32'd2);

    // Drops at bytes 3 and 9 must not disturb the snapshot
    set_coords(16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 16'h0F0F, 16'hF0F0);
    build_pkt(8'h02, 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 16'h0F0F, 16'hF0F0);
    send_frame();
    set_coords(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    rx_packet(1'b0, 15'h0208);
    chk("drop_count", 32'(dropped_count), 32'd2);
    chk("drop_seq", 32'(seq), 32'd3);
    chk("drop_idle", 32'(tx_valid), 32'd0);

    // Frame accepted on the byte-14 transfer starts the next packet with no gap
    set_coords(16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6);
    build_pkt(8'h03, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6);
    send_frame();
    set_coords(16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    rx_packet(1'b0, 15'h4000);
    exp_pkt = '{8'hA5, 8'h04, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00,
                8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02};
    rx_packet(1'b0, 15'h0000);
    chk("bnd_dropped", 32'(dropped_count), 32'd2);
    chk("bnd_seq", 32'(seq), 32'd5);

    // Saturation: 300 drops while stalled on the sync byte
    set_coords(16'h0101, 16'h0202, 16'h0303, 16'h0404, 16'h0505, 16'h0606);
    build_pkt(8'h05, 16'h0101, 16'h0202, 16'h0303, 16'h0404, 16'h0505, 16'h0606);
    send_frame();
    tx_ready   = 1'b0;
    frame_done = 1'b1;
    repeat (252) tick();
    chk("sat_254", 32'(dropped_count), 32'd254);
    repeat (48) tick();
    frame_done = 1'b0;
    chk("sat_255", 32'(dropped_count), 32'd255);
    chk("sat_stall_data", 32'(tx_data), 32'hA5);
    rx_packet(1'b0, 15'h0000);
    chk("sat_seq", 32'(seq), 32'd6);
    chk("sat_hold", 32'(dropped_count), 32'd255);

    // Reset during byte 7
    set_coords(16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666);
    build_pkt(8'h06, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666);
    send_frame();
    for (int b = 0; b < 7; b++) begin
      chk($sformatf("pre_rst_data[%0d]", b), 32'(tx_data), 32'(exp_pkt[b]));
      tick();
    end
    chk("pre_rst_data[7]", 32'(tx_data), 32'(exp_pkt[7]));
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("mid_rst_valid", 32'(tx_valid), 32'd0);
    chk("mid_rst_seq", 32'(seq), 32'd0);
    chk("mid_rst_dropped", 32'(dropped_count), 32'd0);
    tick();

    // 257 back-to-back packets of 0x8080: seq wraps, checksum equals seq
    set_coords(16'h8080, 16'h8080, 16'h8080, 16'h8080, 16'h8080, 16'h8080);
    send_frame();
    for (int p = 0; p < 257; p++) begin
      build_pkt(8'(p), 16'h8080, 16'h8080, 16'h8080, 16'h8080, 16'h8080, 16'h8080);
      rx_packet(1'b0, (p < 256) ? 15'h4000 : 15'h0000);
    end
    chk("wrap_seq", 32'(seq), 32'd1);
    chk("wrap_idle", 32'(busy), 32'd0);
    chk("wrap_dropped", 32'(dropped_count), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
